// File: rtl/bfp_mul_pipe.sv
// Pipelined FP multiplier (default bfloat16), RNE, FTZ; BFP_MUL_FLAGS_EN adds out_flags.
// Latency 3 cycles accept-to-out_valid, throughput 1/cycle.
// Global stall: every stage holds while out_valid & !out_ready; in_ready follows.
module bfp_mul_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 7,
   parameter int N_BIT = 1 + EXP_W + MAN_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_BIT-1:0] a,
   input  logic [N_BIT-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N_BIT-1:0] out_data
`ifdef BFP_MUL_FLAGS_EN
   ,output logic [3:0]      out_flags
`endif
);

   localparam int SIG_W = MAN_W + 1;
   localparam int PW    = 2 * SIG_W;
   localparam int EW    = EXP_W + 2;
   localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);
   localparam logic [N_BIT-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   logic en;
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // ---------------- S1: classify, exponent sum, significand product
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic [SIG_W-1:0] sig_a, sig_b;
   logic             a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
   logic signed [EW-1:0] e_sum;
   logic [PW-1:0]    cs_sum, cs_cry, prod;

   assign ea     = a[N_BIT-2 -: EXP_W];
   assign eb     = b[N_BIT-2 -: EXP_W];
   assign fa     = a[MAN_W-1:0];
   assign fb     = b[MAN_W-1:0];
   assign sig_a  = {1'b1, fa};
   assign sig_b  = {1'b1, fb};
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_nan  = (&ea) && (|fa);
   assign b_nan  = (&eb) && (|fb);
   assign a_inf  = (&ea) && !(|fa);
   assign b_inf  = (&eb) && !(|fb);
   assign e_sum  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

   // Partial products folded one row at a time through 3:2 compressors;
   // bits carried past PW are dropped since the true product fits in PW.
   always_comb begin : csa_tree
      logic [PW-1:0] pp, x, y;
      cs_sum = '0;
      cs_cry = '0;
      for (int i = 0; i < SIG_W; i++) begin
         pp     = sig_b[i] ? (PW'(sig_a) << i) : '0;
         x      = cs_sum;
         y      = cs_cry;
         cs_sum = x ^ y ^ pp;
         cs_cry = ((x & y) | (x & pp) | (y & pp)) << 1;
      end
   end
   assign prod = cs_sum + cs_cry;

   logic                 s1_vld, s1_sign, s1_nan, s1_inf, s1_zero;
   logic signed [EW-1:0] s1_exp;
   logic [PW-1:0]        s1_prod;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld  <= 1'b0;
         s1_sign <= 1'b0;
         s1_nan  <= 1'b0;
         s1_inf  <= 1'b0;
         s1_zero <= 1'b0;
         s1_exp  <= '0;
         s1_prod <= '0;
      end else if (en) begin
         s1_vld  <= in_valid;
         s1_sign <= a[N_BIT-1] ^ b[N_BIT-1];
         s1_nan  <= a_nan || b_nan;
         s1_inf  <= a_inf || b_inf;
         s1_zero <= a_zero || b_zero;
         s1_exp  <= e_sum;
         s1_prod <= prod;
      end
   end

   // ---------------- S2: normalise and round to nearest even
   // norm drops the hidden bit: fraction, then guard, then sticky bits.
   logic [PW-2:0]        norm;
   logic [MAN_W-1:0]     frac, frac_rnd;
   logic                 guard, sticky, rnd_up, rnd_cry;
   logic signed [EW-1:0] e_norm;

   assign norm     = s1_prod[PW-1] ? s1_prod[PW-2:0] : {s1_prod[PW-3:0], 1'b0};
   assign frac     = norm[PW-2 -: MAN_W];
   assign guard    = norm[MAN_W];
   assign sticky   = |norm[MAN_W-1:0];
   assign rnd_up   = guard && (sticky || frac[0]);
   assign rnd_cry  = rnd_up && (&frac);
   assign frac_rnd = frac + {{(MAN_W-1){1'b0}}, rnd_up};
   assign e_norm   = s1_exp + {{(EW-1){1'b0}}, s1_prod[PW-1]} + {{(EW-1){1'b0}}, rnd_cry};

   logic                 s2_vld, s2_sign, s2_nan, s2_inf, s2_zero;
   logic signed [EW-1:0] s2_exp;
   logic [MAN_W-1:0]     s2_frac;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_vld  <= 1'b0;
         s2_sign <= 1'b0;
         s2_nan  <= 1'b0;
         s2_inf  <= 1'b0;
         s2_zero <= 1'b0;
         s2_exp  <= '0;
         s2_frac <= '0;
      end else if (en) begin
         s2_vld  <= s1_vld;
         s2_sign <= s1_sign;
         s2_nan  <= s1_nan;
         s2_inf  <= s1_inf;
         s2_zero <= s1_zero;
         s2_exp  <= e_norm;
         s2_frac <= frac_rnd;
      end
   end

   // ---------------- S3: special values, range check, pack
   logic             sp_nan, finite, ovf, unf;
   logic [N_BIT-1:0] res;

   assign sp_nan = s2_nan || (s2_inf && s2_zero);
   assign finite = !(s2_nan || s2_inf || s2_zero);
   assign ovf    = finite && (s2_exp >= E_MAX);
   assign unf    = finite && (s2_exp[EW-1] || (s2_exp == '0));

   always_comb begin
      res = {s2_sign, s2_exp[EXP_W-1:0], s2_frac};
      if (sp_nan)
         res = QNAN;
      else if (s2_inf || ovf)
         res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (s2_zero || unf)
         res = {s2_sign, {(N_BIT-1){1'b0}}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (en) begin
         out_valid <= s2_vld;
         out_data  <= res;
      end
   end

`ifdef BFP_MUL_FLAGS_EN
   logic s2_inexact;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_inexact <= 1'b0;
         out_flags  <= '0;
      end else if (en) begin
         s2_inexact <= guard || sticky;
         out_flags  <= {sp_nan, ovf, unf, ovf || unf || (finite && s2_inexact)};
      end
   end
`endif

endmodule
